// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard/stall controller: load-use bubbles, taken-branch squash, memory freeze and timeout.
// Optional stall/flush statistics counters are built only when HAZ_STATS_EN is defined.
module hazard_stall_ctrl #(
    parameter int REG_ZERO    = 31,
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rn,
    input  logic [4:0]       id_rm,
    input  logic             id_uses_rn,
    input  logic             id_uses_rm,
    input  logic [4:0]       ex_rd,
    input  logic             ex_read_enable,
    input  logic             ex_regwrite,
    input  logic             br_taken_ex,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_we,
    output logic             ifid_we,
    output logic             ifid_flush,
    output logic             idex_we,
    output logic             idex_bubble,
    output logic             exmem_we,
    output logic             memwb_bubble,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } state_t;

    localparam logic [4:0] ZERO_IDX = 5'(REG_ZERO);
    localparam logic [6:0] WCNT_MAX = 7'(MEM_TIMEOUT);

    state_t     state_q, state_d;
    logic [6:0] wcnt_q, wcnt_d;
    logic       lu;
    logic       ms;

    assign lu = ex_read_enable & ex_regwrite & (ex_rd != ZERO_IDX) &
                ((id_uses_rn & (id_rn == ex_rd)) | (id_uses_rm & (id_rm == ex_rd)));
    assign ms = mem_req & ~mem_ready;

    always_comb begin
        state_d      = state_q;
        wcnt_d       = wcnt_q;
        pc_we        = 1'b1;
        ifid_we      = 1'b1;
        ifid_flush   = 1'b0;
        idex_we      = 1'b1;
        idex_bubble  = 1'b0;
        exmem_we     = 1'b1;
        memwb_bubble = 1'b0;

        case (state_q)
            RUN: begin
                if (ms) begin
                    pc_we        = 1'b0;
                    ifid_we      = 1'b0;
                    idex_we      = 1'b0;
                    exmem_we     = 1'b0;
                    memwb_bubble = 1'b1;
                    state_d      = MEM_WAIT;
                    wcnt_d       = 7'd1;
                end else if (br_taken_ex) begin
                    // Branch squash wins over any load-use match on the wrong-path instruction.
                    ifid_flush  = 1'b1;
                    idex_bubble = 1'b1;
                end else if (lu) begin
                    pc_we       = 1'b0;
                    ifid_we     = 1'b0;
                    idex_bubble = 1'b1;
                end
            end
            MEM_WAIT: begin
                pc_we        = 1'b0;
                ifid_we      = 1'b0;
                idex_we      = 1'b0;
                exmem_we     = 1'b0;
                memwb_bubble = 1'b1;
                if (mem_ready) begin
                    state_d = RUN;
                    wcnt_d  = 7'd0;
                end else if (wcnt_q == WCNT_MAX) begin
                    state_d = ERROR;
                end else begin
                    wcnt_d = wcnt_q + 7'd1;
                end
            end
            default: begin
                // ERROR (and any illegal encoding) keeps the pipe frozen until reset.
                pc_we        = 1'b0;
                ifid_we      = 1'b0;
                idex_we      = 1'b0;
                exmem_we     = 1'b0;
                memwb_bubble = 1'b1;
                state_d      = ERROR;
            end
        endcase

        if (reset) begin
            pc_we        = 1'b0;
            ifid_we      = 1'b0;
            idex_we      = 1'b0;
            exmem_we     = 1'b0;
            ifid_flush   = 1'b1;
            idex_bubble  = 1'b1;
            memwb_bubble = 1'b1;
            state_d      = RUN;
            wcnt_d       = 7'd0;
        end
    end

    always_ff @(posedge clk) begin
        state_q <= state_d;
        wcnt_q  <= wcnt_d;
    end

    assign mem_timeout = (state_q == ERROR);

`ifdef HAZ_STATS_EN
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] flush_q, flush_d;
    logic             flush_ev;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign flush_ev = (state_q == RUN) & ~ms & br_taken_ex & ~reset;

    always_comb begin
        stall_d = stall_q;
        flush_d = flush_q;
        if (reset) begin
            stall_d = '0;
            flush_d = '0;
        end else begin
            if (!pc_we)   stall_d = sat_inc(stall_q);
            if (flush_ev) flush_d = sat_inc(flush_q);
        end
    end

    always_ff @(posedge clk) begin
        stall_q <= stall_d;
        flush_q <= flush_d;
    end

    assign stall_cycles = stall_q;
    assign flush_count  = flush_q;
`else
    assign stall_cycles = '0;
    assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: vector table of single-cycle RUN cases plus multi-cycle
// memory-freeze, timeout and reset sequences, checked through an expectation queue.
module tb_hazard_stall_ctrl;

    localparam int CNT_W = 16;
`ifdef HAZ_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    // Output vector order: pc_we, ifid_we, ifid_flush, idex_we, idex_bubble, exmem_we, memwb_bubble
    localparam logic [6:0] O_RUN = 7'b1101010;
    localparam logic [6:0] O_FRZ = 7'b0000001;
    localparam logic [6:0] O_BR  = 7'b1111110;
    localparam logic [6:0] O_LU  = 7'b0001110;
    localparam logic [6:0] O_RST = 7'b0010101;

    logic clk = 1'b0;
    logic reset;
    logic [4:0] id_rn, id_rm, ex_rd;
    logic id_uses_rn, id_uses_rm, ex_read_enable, ex_regwrite;
    logic br_taken_ex, mem_req, mem_ready;
    logic pc_we, ifid_we, ifid_flush, idex_we, idex_bubble, exmem_we, memwb_bubble, mem_timeout;
    logic [CNT_W-1:0] stall_cycles, flush_count;

    always #5 clk = ~clk;

    hazard_stall_ctrl #(.REG_ZERO(31), .MEM_TIMEOUT(4), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .id_rn(id_rn), .id_rm(id_rm), .id_uses_rn(id_uses_rn), .id_uses_rm(id_uses_rm),
        .ex_rd(ex_rd), .ex_read_enable(ex_read_enable), .ex_regwrite(ex_regwrite),
        .br_taken_ex(br_taken_ex), .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_we(pc_we), .ifid_we(ifid_we), .ifid_flush(ifid_flush), .idex_we(idex_we),
        .idex_bubble(idex_bubble), .exmem_we(exmem_we), .memwb_bubble(memwb_bubble),
        .mem_timeout(mem_timeout), .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    typedef struct {
        logic       rst;
        logic [4:0] rn;
        logic       urn;
        logic [4:0] rm;
        logic       urm;
        logic [4:0] rd;
        logic       re;
        logic       rw;
        logic       br;
        logic       mreq;
        logic       mrdy;
        logic [6:0] outs;
        logic       to;
    } vec_t;

    typedef struct {
        int               id;
        logic [6:0]       outs;
        logic             to;
        logic [CNT_W-1:0] stall;
        logic [CNT_W-1:0] flush;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;
    int step_no = 0;
    logic [CNT_W-1:0] exp_stall = '0;
    logic [CNT_W-1:0] exp_flush = '0;
    vec_t tbl[12];

    function automatic vec_t mk(input logic rst, input logic [4:0] rn, input logic urn,
                                input logic [4:0] rm, input logic urm, input logic [4:0] rd,
                                input logic re, input logic rw, input logic br,
                                input logic mreq, input logic mrdy,
                                input logic [6:0] outs, input logic to);
        vec_t v;
        v.rst = rst; v.rn = rn; v.urn = urn; v.rm = rm; v.urm = urm; v.rd = rd;
        v.re = re; v.rw = rw; v.br = br; v.mreq = mreq; v.mrdy = mrdy;
        v.outs = outs; v.to = to;
        return v;
    endfunction

    task automatic compare_front();
        exp_t e;
        logic [6:0] act;
        logic [CNT_W-1:0] want_stall, want_flush;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty step%0d", step_no);
            return;
        end
        e = sb.pop_front();
        act = {pc_we, ifid_we, ifid_flush, idex_we, idex_bubble, exmem_we, memwb_bubble};
        want_stall = STATS ? e.stall : '0;
        want_flush = STATS ? e.flush : '0;
        checks++;
        if (act !== e.outs) begin
            errors++;
            $display("FAIL step%0d ctrl_outs got %b want %b", e.id, act, e.outs);
        end
        checks++;
        if (mem_timeout !== e.to) begin
            errors++;
            $display("FAIL step%0d mem_timeout got %b want %b", e.id, mem_timeout, e.to);
        end
        checks++;
        if (stall_cycles !== want_stall) begin
            errors++;
            $display("FAIL step%0d stall_cycles got %0d want %0d", e.id, stall_cycles, want_stall);
        end
        checks++;
        if (flush_count !== want_flush) begin
            errors++;
            $display("FAIL step%0d flush_count got %0d want %0d", e.id, flush_count, want_flush);
        end
    endtask

    // Called one time unit after a rising edge; returns one time unit after the next one.
    task automatic step(input vec_t v);
        exp_t e;
        reset = v.rst; id_rn = v.rn; id_uses_rn = v.urn; id_rm = v.rm; id_uses_rm = v.urm;
        ex_rd = v.rd; ex_read_enable = v.re; ex_regwrite = v.rw; br_taken_ex = v.br;
        mem_req = v.mreq; mem_ready = v.mrdy;
        step_no++;
        e.id = step_no; e.outs = v.outs; e.to = v.to; e.stall = exp_stall; e.flush = exp_flush;
        sb.push_back(e);
        @(negedge clk);
        compare_front();
        if (v.rst) begin
            exp_stall = '0;
            exp_flush = '0;
        end else begin
            if (!v.outs[6] && exp_stall != '1) exp_stall = exp_stall + 1'b1;
            if (v.outs[6] && v.outs[4] && exp_flush != '1) exp_flush = exp_flush + 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t idle;
        idle = mk(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 0, 0, O_RUN, 0);

        tbl[0]  = idle;
        tbl[1]  = mk(0, 5'd3,  1, 5'd9,  0, 5'd3,  1, 1, 0, 0, 0, O_LU,  0); // LDUR X3 then use via Rn
        tbl[2]  = idle;
        tbl[3]  = mk(0, 5'd31, 1, 5'd0,  0, 5'd31, 1, 1, 0, 0, 0, O_RUN, 0); // XZR destination
        tbl[4]  = mk(0, 5'd1,  1, 5'd7,  1, 5'd7,  1, 1, 0, 0, 0, O_LU,  0); // match via Rm
        tbl[5]  = mk(0, 5'd1,  1, 5'd7,  0, 5'd7,  1, 1, 0, 0, 0, O_RUN, 0); // Rm not read
        tbl[6]  = mk(0, 5'd5,  1, 5'd0,  0, 5'd5,  1, 0, 0, 0, 0, O_RUN, 0); // load without regwrite
        tbl[7]  = mk(0, 5'd5,  1, 5'd0,  0, 5'd5,  0, 1, 0, 0, 0, O_RUN, 0); // ALU op, forwarded
        tbl[8]  = mk(0, 5'd3,  1, 5'd0,  0, 5'd3,  1, 1, 1, 0, 0, O_BR,  0); // branch kills load-use
        tbl[9]  = mk(0, 5'd0,  0, 5'd0,  0, 5'd0,  0, 0, 1, 0, 0, O_BR,  0); // plain taken branch
        tbl[10] = mk(0, 5'd0,  0, 5'd0,  0, 5'd0,  0, 0, 0, 1, 1, O_RUN, 0); // single-cycle memory
        tbl[11] = mk(0, 5'd4,  0, 5'd6,  1, 5'd4,  1, 1, 0, 0, 0, O_RUN, 0); // Rn match but unused

        reset = 1'b1; id_rn = '0; id_rm = '0; id_uses_rn = 0; id_uses_rm = 0; ex_rd = '0;
        ex_read_enable = 0; ex_regwrite = 0; br_taken_ex = 0; mem_req = 0; mem_ready = 0;
        @(posedge clk);
        #1;

        // Reset state
        step(mk(1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 0, 0, O_RST, 0));
        step(mk(1, 5'd3, 1, 5'd0, 0, 5'd3, 1, 1, 1, 1, 0, O_RST, 0));

        for (int i = 0; i < 12; i++) step(tbl[i]);

        // Memory freeze: three not-ready cycles then ready, hazards ignored while frozen
        step(mk(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 1, 0, O_FRZ, 0));
        step(mk(0, 5'd3, 1, 5'd0, 0, 5'd3, 1, 1, 1, 1, 0, O_FRZ, 0));
        step(mk(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 1, 0, O_FRZ, 0));
        step(mk(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 1, 1, O_FRZ, 0));
        step(idle);

        // Timeout with MEM_TIMEOUT=4: five frozen cycles, then sticky ERROR until reset
        for (int i = 0; i < 5; i++) step(mk(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 1, 0, O_FRZ, 0));
        step(mk(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 1, 0, O_FRZ, 1));
        step(mk(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 1, 1, 1, O_FRZ, 1));
        step(mk(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 0, 0, O_FRZ, 1));
        step(mk(1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 0, 0, O_RST, 1));
        step(idle);

        // Reset during the second MEM_WAIT cycle; wait counter must restart from zero
        step(mk(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 1, 0, O_FRZ, 0));
        step(mk(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 1, 0, O_FRZ, 0));
        step(mk(1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 1, 0, O_RST, 0));
        step(idle);
        for (int i = 0; i < 5; i++) step(mk(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 1, 0, O_FRZ, 0));
        step(mk(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 1, 0, O_FRZ, 1));
        step(mk(1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 0, 0, O_RST, 1));
        step(idle);

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover got %0d want 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
